// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port synchronous RAM.
// Data has priority and a starvation counter bounds how long fetch waits.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                i_flush,
  output logic                i_gnt,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_ren,
  input  logic [DATA_W/8-1:0] d_wen,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_stall,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_ren,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INST = 2'd1;
  localparam logic [1:0] OWN_DATA = 2'd2;

  logic [CNT_W-1:0] starve_cnt;
  logic [1:0]       rd_owner;
  logic [1:0]       owner_nxt;
  logic             d_wr;
  logic             d_req;
  logic             starved;
  logic             gnt_i;
  logic             gnt_d;

  assign d_wr    = |d_wen;
  assign d_req   = d_ren | d_wr;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // A flushed fetch never wins, so data can use that cycle.
  assign gnt_i = i_req & ~i_flush & (~d_req | starved);
  assign gnt_d = d_req & ~gnt_i;

  assign i_gnt   = rstn & gnt_i;
  assign d_gnt   = rstn & gnt_d;
  assign d_stall = rstn & d_req & ~gnt_d;

  always_comb begin
    ram_addr  = '0;
    ram_ren   = 1'b0;
    ram_wen   = '0;
    ram_wdata = '0;
    unique case (1'b1)
      i_gnt: begin
        ram_addr = i_addr;
        ram_ren  = 1'b1;
      end
      d_gnt: begin
        ram_addr = d_addr;
        if (d_wr) begin
          ram_wen   = d_wen;
          ram_wdata = d_wdata;
        end else begin
          ram_ren = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_nxt = OWN_NONE;
    unique case (1'b1)
      i_gnt:         owner_nxt = OWN_INST;
      d_gnt & ~d_wr: owner_nxt = OWN_DATA;
      default:       owner_nxt = OWN_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (i_req & ~i_gnt & ~i_flush) begin
      if (!starved)
        starve_cnt <= starve_cnt + CNT_W'(1);
    end else begin
      starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rd_owner <= OWN_NONE;
    else
      rd_owner <= owner_nxt;
  end

  assign i_rvalid = (rd_owner == OWN_INST) & ~i_flush;
  assign d_rvalid = (rd_owner == OWN_DATA);
  assign i_rdata  = i_rvalid ? ram_rdata : '0;
  assign d_rdata  = d_rvalid ? ram_rdata : '0;

  logic unused_be;
  assign unused_be = (BE_W == 0);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural RAM.
// Each cycle pushes the expected response and pops the previous one.
module tb_mem_arbiter;

  logic        clk;
  logic        rstn;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_flush;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_ren;
  logic [3:0]  d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_stall;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] ram_addr;
  logic        ram_ren;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  logic [31:0] mem [0:1023];
  logic [65:0] exp_q [$];
  logic [39:0] gx;
  logic [65:0] rx;
  int total;
  int bad;

  wire [39:0] gvec = {i_gnt, d_gnt, d_stall, ram_ren, ram_wen, ram_addr};
  wire [65:0] rvec = {i_rvalid, d_rvalid, i_rdata, d_rdata};

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
    .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_stall(d_stall),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_addr(ram_addr), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] golden(input logic [31:0] a);
    return 32'hC0DE0000 ^ a;
  endfunction

  function automatic logic [65:0] mk_rsp(input logic [1:0] own,
                                         input logic [31:0] data);
    return {own == 2'd1, own == 2'd2,
            (own == 2'd1) ? data : 32'h0,
            (own == 2'd2) ? data : 32'h0};
  endfunction

  initial begin
    for (int k = 0; k < 1024; k++) mem[k] = golden(32'(k * 4));
    ram_rdata = 32'h0;
  end

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_addr[11:2]];
    for (int b = 0; b < 4; b++)
      if (ram_wen[b]) mem[ram_addr[11:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
  end

  task automatic drive(input logic ir, input logic [31:0] ia,
                       input logic fl, input logic dr,
                       input logic [3:0] dw, input logic [31:0] da,
                       input logic [31:0] dd);
    @(posedge clk);
    #1;
    i_req = ir; i_addr = ia; i_flush = fl;
    d_ren = dr; d_wen = dw; d_addr = da; d_wdata = dd;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    i_req = 1'b1; i_addr = 32'h100; i_flush = 1'b0;
    d_ren = 1'b1; d_wen = 4'h0; d_addr = 32'h200; d_wdata = 32'h0;
    @(negedge clk);
    total += 3;
    if (gvec !== 40'h0) begin
      bad++; $display("FAIL reset_gnt got=%h want=%h", gvec, 40'h0);
    end
    if (rvec !== 66'h0) begin
      bad++; $display("FAIL reset_rsp got=%h want=%h", rvec, 66'h0);
    end
    if (ram_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_wdata got=%h want=0", ram_wdata);
    end
    exp_q.push_back(mk_rsp(2'd0, 32'h0));
    @(posedge clk);
    #1;
    rstn = 1'b1;
    i_req = 1'b0; d_ren = 1'b0;
    exp_q.push_back(mk_rsp(2'd0, 32'h0));
    @(negedge clk);
    gx = 40'h0; rx = exp_q.pop_front(); total += 2;
    if (gvec !== gx) begin
      bad++; $display("FAIL idle_gnt got=%h want=%h", gvec, gx);
    end
    if (rvec !== rx) begin
      bad++; $display("FAIL idle_rsp got=%h want=%h", rvec, rx);
    end
  endtask

  task automatic test_fetch;
    for (int c = 0; c < 2; c++) begin
      if (c == 0) begin
        drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_q.push_back(mk_rsp(2'd1, golden(32'h100)));
        gx = {4'b1001, 4'h0, 32'h100};
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_q.push_back(mk_rsp(2'd0, 32'h0));
        gx = 40'h0;
      end
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL fetch_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL fetch_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
    end
  endtask

  task automatic test_priority;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) begin
        drive(1'b1, 32'h100, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0);
        exp_q.push_back(mk_rsp(2'd2, golden(32'h200)));
        gx = {4'b0101, 4'h0, 32'h200};
      end else if (c == 1) begin
        drive(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_q.push_back(mk_rsp(2'd1, golden(32'h100)));
        gx = {4'b1001, 4'h0, 32'h100};
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_q.push_back(mk_rsp(2'd0, 32'h0));
        gx = 40'h0;
      end
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL prio_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL prio_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
    end
  endtask

  task automatic test_starvation;
    logic [31:0] da;
    for (int c = 0; c < 7; c++) begin
      da = 32'h200 + 32'(4 * c);
      if (c < 4 || c == 5) begin
        drive(1'b1, 32'h104, 1'b0, 1'b1, 4'h0, da, 32'h0);
        exp_q.push_back(mk_rsp(2'd2, golden(da)));
        gx = {4'b0101, 4'h0, da};
      end else if (c == 4) begin
        drive(1'b1, 32'h104, 1'b0, 1'b1, 4'h0, da, 32'h0);
        exp_q.push_back(mk_rsp(2'd1, golden(32'h104)));
        gx = {4'b1011, 4'h0, 32'h104};
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        exp_q.push_back(mk_rsp(2'd0, 32'h0));
        gx = 40'h0;
      end
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL starve_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL starve_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
      if (c == 4 || c == 5) begin
        total++;
        if (dut.starve_cnt !== ((c == 4) ? 3'd4 : 3'd0)) begin
          bad++;
          $display("FAIL starve_cnt c%0d got=%0d want=%0d",
                   c, dut.starve_cnt, (c == 4) ? 4 : 0);
        end
      end
    end
  endtask

  task automatic test_write;
    logic [31:0] m0;
    logic [31:0] m1;
    m0 = (golden(32'h300) & 32'hFF00FFFF) | 32'h00AB0000;
    m1 = (golden(32'h304) & 32'hFFFFFF00) | 32'h0000005A;
    for (int c = 0; c < 5; c++) begin
      unique case (c)
        0: begin
          drive(1'b0, 32'h0, 1'b0, 1'b0, 4'b0100, 32'h300, 32'h00AB0000);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = {4'b0100, 4'b0100, 32'h300};
        end
        1: begin
          drive(1'b0, 32'h0, 1'b0, 1'b1, 4'b0001, 32'h304, 32'h0000005A);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = {4'b0100, 4'b0001, 32'h304};
        end
        2: begin
          drive(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h300, 32'h0);
          exp_q.push_back(mk_rsp(2'd2, m0));
          gx = {4'b0101, 4'h0, 32'h300};
        end
        3: begin
          drive(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h304, 32'h0);
          exp_q.push_back(mk_rsp(2'd2, m1));
          gx = {4'b0101, 4'h0, 32'h304};
        end
        default: begin
          drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = 40'h0;
        end
      endcase
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL write_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL write_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
      if (c == 0) begin
        total++;
        if (ram_wdata !== 32'h00AB0000) begin
          bad++;
          $display("FAIL write_wdata got=%h want=%h", ram_wdata, 32'h00AB0000);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int c = 0; c < 4; c++) begin
      unique case (c)
        0: begin
          drive(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h208, 32'h0);
          exp_q.push_back(mk_rsp(2'd2, golden(32'h208)));
          gx = {4'b0101, 4'h0, 32'h208};
        end
        1: begin
          drive(1'b1, 32'h110, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd1, golden(32'h110)));
          gx = {4'b1001, 4'h0, 32'h110};
        end
        2: begin
          drive(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h20C, 32'h0);
          exp_q.push_back(mk_rsp(2'd2, golden(32'h20C)));
          gx = {4'b0101, 4'h0, 32'h20C};
        end
        default: begin
          drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = 40'h0;
        end
      endcase
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL b2b_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL b2b_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
    end
  endtask

  task automatic test_flush;
    for (int c = 0; c < 4; c++) begin
      unique case (c)
        0: begin
          drive(1'b1, 32'h114, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = {4'b1001, 4'h0, 32'h114};
        end
        1: begin
          drive(1'b1, 32'h118, 1'b1, 1'b1, 4'h0, 32'h210, 32'h0);
          exp_q.push_back(mk_rsp(2'd2, golden(32'h210)));
          gx = {4'b0101, 4'h0, 32'h210};
        end
        2: begin
          drive(1'b1, 32'h118, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = 40'h0;
        end
        default: begin
          drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
          exp_q.push_back(mk_rsp(2'd0, 32'h0));
          gx = 40'h0;
        end
      endcase
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL flush_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL flush_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
    end
  endtask

  task automatic test_reset_midread;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) begin
        drive(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h200, 32'h0);
        gx = {4'b0101, 4'h0, 32'h200};
      end else begin
        drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        gx = 40'h0;
      end
      if (c == 1) rstn = 1'b0;
      if (c == 2) rstn = 1'b1;
      exp_q.push_back(mk_rsp(2'd0, 32'h0));
      @(negedge clk);
      rx = exp_q.pop_front(); total += 2;
      if (gvec !== gx) begin
        bad++; $display("FAIL rstmid_gnt c%0d got=%h want=%h", c, gvec, gx);
      end
      if (rvec !== rx) begin
        bad++; $display("FAIL rstmid_rsp c%0d got=%h want=%h", c, rvec, rx);
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_fetch();
    test_priority();
    test_starvation();
    test_write();
    test_back_to_back();
    test_flush();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port synchronous RAM between the instruction-fetch port and the load/store data port. The data port side already carries formatted write data, byte enables and read enable. The arbiter sits between those requesters and the RAM. It grants at most one access per cycle and tags each read so its data returns to the right requester one cycle later. Data accesses have priority, and a starvation counter bounds how long fetch can be blocked.

## Interface
Parameters:
- ADDR_W, 32, address width of both ports and the RAM.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, consecutive denied fetch cycles after which fetch wins over data (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request (read only); held until granted.
- i_addr  in  ADDR_W  fetch address.
- i_flush  in  1  cancel fetch traffic (branch/trap redirect).
- i_gnt  out  1  fetch granted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  DATA_W  fetch read data.
- d_ren  in  1  data read request.
- d_wen  in  DATA_W/8  data write byte enables; nonzero = write request.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  data write data.
- d_gnt  out  1  data access granted this cycle.
- d_stall  out  1  data request present but not granted.
- d_rvalid  out  1  data read data valid.
- d_rdata  out  DATA_W  data read data.
- ram_addr  out  ADDR_W  RAM address.
- ram_ren  out  1  RAM read enable.
- ram_wen  out  DATA_W/8  RAM byte write enables.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after ram_ren.

## Operation
- A data request is d_ren | (|d_wen). If both are set, the access is a write and d_ren is ignored.
- Grant selection, combinational:
  - Data only: data wins.
  - Fetch only: fetch wins unless i_flush is high.
  - Both: data wins unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - i_flush high: i_gnt = 0 that cycle, and data may be granted.
- d_stall = data request & ~d_gnt.
- RAM mux:
  - Granted port drives ram_addr.
  - Fetch grant: ram_ren = 1, ram_wen = 0.
  - Data read grant: ram_ren = 1.
  - Data write grant: ram_wen = d_wen, ram_wdata = d_wdata, ram_ren = 0.
  - No grant: ram_addr, ram_ren, ram_wen and ram_wdata are all 0.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on every edge where i_req & ~i_gnt & ~i_flush.
  - Clears on an edge where i_gnt, ~i_req or i_flush holds.
- Read tag register rd_owner (NONE/INST/DATA):
  - Loads INST on a fetch grant and DATA on a data read grant.
  - Loads NONE when there is no grant or on a data write.
- Responses:
  - i_rvalid = (rd_owner == INST) & ~i_flush; d_rvalid = (rd_owner == DATA).
  - Each rdata equals ram_rdata when its rvalid is high and is 0 otherwise.
- Writes produce no response; d_gnt is their completion.

## Timing
- Reset: rd_owner = NONE and starve_cnt = 0.
  - Outputs are 0 while rstn is low: i_rvalid, d_rvalid, i_rdata, d_rdata.
  - Grants and RAM drives are combinational from inputs but are forced to 0 while rstn is low.
- Grant latency: 0 cycles, with the grant in the same cycle as the request.
- Read data latency: 1 cycle after the grant.
- Write commit: at the edge that ends the grant cycle.
- Throughput: one access per cycle. Back-to-back grants are pipelined, so the response for grant N appears in the same cycle as grant N+1.
- Fetch worst-case wait under continuous data traffic: STARVE_LIMIT cycles, then granted in the next cycle.
- i_flush in the response cycle kills that fetch response. The tag is still consumed, and the data port is unaffected.
- Reset asserted mid-read drops the in-flight response; no rvalid appears after release.
- Requesters must hold address, data and enables stable until granted. The arbiter does not register request payloads.

## Test plan
- Reset then idle:
  - All outputs are 0.
  - i_req with i_addr=0x100 -> i_gnt the same cycle, ram_addr=0x100, ram_ren=1.
  - Next cycle: i_rvalid=1, i_rdata = RAM word at 0x100.
- Simultaneous i_req and d_ren at 0x200 -> d_gnt=1, i_gnt=0, d_stall=0. Next cycle: d_rvalid=1, i_rvalid=0.
- Starvation, with STARVE_LIMIT=4:
  - Hold i_req and a continuous d_ren -> d_gnt for 4 cycles, then i_gnt on the 5th with d_stall=1.
  - starve_cnt returns to 0 afterwards.
- Byte write d_wen=4'b0100, d_wdata=0x00AB0000 at 0x300:
  - ram_wen=4'b0100 in the grant cycle, with no d_rvalid.
  - A following read of 0x300 returns byte 2 = 0xAB.
- Pipelined alternating reads D, I, D on consecutive cycles -> responses d_rvalid, i_rvalid, d_rvalid on the next three cycles, each with the matching data.
- Flush behaviour:
  - i_flush in the cycle after a fetch grant -> i_rvalid=0 and i_rdata=0.
  - Assert rstn low during an outstanding read -> no rvalid after release.
